clock_ctrl: RTL and testbench

Mode and time-base controller for the digital-clock datapath. Divides the system clock into a 1 Hz tick and issues one-cycle advance pulses to the BCD seconds (00-59), minutes (00-59) and hours (00-23) counters, chaining carries from their at-max flags. A three-state mode FSM lets the user set hours and minutes with two buttons. A blink enable drives the display during set modes.

---
 rtl/clock_ctrl.sv | 141 ++++++++++++++
 tb/tb_clock_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - Digital-clock time base, set-mode FSM and blink control
module clock_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       sec_at_max,
    input  logic       min_at_max,
    output logic       sec_adv,
    output logic       min_adv,
    output logic       hour_adv,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    state_t state;
    state_t next_state;

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_d;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_d;
    logic          blink_d;
    logic          mode_prev;
    logic          inc_prev;
    logic          sec_adv_d;
    logic          min_adv_d;
    logic          hour_adv_d;
    logic          sec_clr_d;

    logic mode_rise;
    logic inc_rise;
    logic tick;

    assign mode_rise = mode_btn & ~mode_prev;
    assign inc_rise  = inc_btn & ~inc_prev;
    assign tick      = (prescaler == PRESC_MAX);
    assign mode      = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:      if (mode_rise) next_state = SET_HOUR;
            SET_HOUR: if (mode_rise) next_state = SET_MIN;
            SET_MIN:  if (mode_rise) next_state = RUN;
            default:  next_state = RUN;
        endcase
    end

    always_comb begin
        sec_adv_d  = 1'b0;
        min_adv_d  = 1'b0;
        hour_adv_d = 1'b0;
        sec_clr_d  = 1'b0;
        case (state)
            RUN: begin
                if (tick) begin
                    sec_adv_d  = 1'b1;
                    min_adv_d  = sec_at_max;
                    hour_adv_d = sec_at_max & min_at_max;
                end
            end
            SET_HOUR: hour_adv_d = inc_rise & ~mode_rise;
            SET_MIN: begin
                min_adv_d = inc_rise & ~mode_rise;
                sec_clr_d = mode_rise;
            end
            default: ;
        endcase
    end

    // Leaving SET_MIN restarts the second so the first tick is a full period away.
    always_comb begin
        prescaler_d = prescaler + PW'(1);
        if (tick || (state == SET_MIN && mode_rise)) begin
            prescaler_d = '0;
        end
    end

    // Blink is forced on whenever RUN is current or next, so entry always starts lit.
    always_comb begin
        blink_cnt_d = blink_cnt + BW'(1);
        blink_d     = blink;
        if (next_state == RUN || state == RUN) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt_d = '0;
            blink_d     = ~blink;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler <= '0;
            blink_cnt <= '0;
            blink     <= 1'b1;
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
            sec_adv   <= 1'b0;
            min_adv   <= 1'b0;
            hour_adv  <= 1'b0;
            sec_clr   <= 1'b0;
        end else begin
            prescaler <= prescaler_d;
            blink_cnt <= blink_cnt_d;
            blink     <= blink_d;
            mode_prev <= mode_btn;
            inc_prev  <= inc_btn;
            sec_adv   <= sec_adv_d;
            min_adv   <= min_adv_d;
            hour_adv  <= hour_adv_d;
            sec_clr   <= sec_clr_d;
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - Self-checking bench for clock_ctrl against a cycle model
module tb_clock_ctrl;

    localparam int TD = 4;
    localparam int BD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       sec_at_max = 1'b0;
    logic       min_at_max = 1'b0;
    logic       sec_adv;
    logic       min_adv;
    logic       hour_adv;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    clock_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec_at_max(sec_at_max), .min_at_max(min_at_max),
        .sec_adv(sec_adv), .min_adv(min_adv), .hour_adv(hour_adv),
        .sec_clr(sec_clr), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: time since last second sync, cycles spent in a set mode, mode as 0..2.
    int m_mode = 0;
    int m_t = 0;
    int m_s = 0;
    bit m_mprev = 1'b1;
    bit m_iprev = 1'b1;
    bit e_sec = 0, e_min = 0, e_hour = 0, e_clr = 0, e_blink = 1;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_mode = 0; m_t = 0; m_s = 0;
            m_mprev = 1; m_iprev = 1;
            e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0; e_blink = 1;
        end else begin
            bit mr, ir;
            int old_mode;
            mr = mode_btn && !m_mprev;
            ir = inc_btn && !m_iprev;
            e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0;
            m_t++;
            if (m_mode == 0 && (m_t % TD) == 0) begin
                e_sec = 1;
                e_min = sec_at_max;
                e_hour = sec_at_max && min_at_max;
            end
            if (m_mode == 1 && ir && !mr) e_hour = 1;
            if (m_mode == 2 && ir && !mr) e_min = 1;
            old_mode = m_mode;
            if (mr) begin
                if (m_mode == 2) begin
                    e_clr = 1;
                    m_t = 0;
                end
                m_mode = (m_mode + 1) % 3;
            end
            if (m_mode == 0) begin
                e_blink = 1;
            end else if (old_mode == 0) begin
                m_s = 0;
                e_blink = 1;
            end else begin
                m_s++;
                e_blink = ((m_s / BD) % 2) == 0;
            end
            m_mprev = mode_btn;
            m_iprev = inc_btn;
        end
    end

    int sec_cnt = 0, min_cnt = 0, hour_cnt = 0, clr_cnt = 0;
    int last_sec = -1, last_clr = -1;
    int sec_times[$];

    always @(negedge clk) begin
        if (checking) begin
            chk("outputs{sec,min,hour,clr,mode,blink}",
                {sec_adv, min_adv, hour_adv, sec_clr, mode, blink},
                {e_sec, e_min, e_hour, e_clr, m_mode[1:0], e_blink});
            if (sec_adv) begin sec_cnt++; last_sec = cyc; sec_times.push_back(cyc); end
            if (min_adv) min_cnt++;
            if (hour_adv) hour_cnt++;
            if (sec_clr) begin clr_cnt++; last_clr = cyc; end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; step(1); mode_btn = 1'b0; step(2);
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; step(1); inc_btn = 1'b0; step(2);
    endtask

    task automatic wait_sec(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * TD; i++) begin
            step(1);
            if (sec_adv) begin seen = 1; break; end
        end
        chk(name, seen, 1);
    endtask

    int rel, s0, m0, h0, c0;

    initial begin
        step(3);
        checking = 1'b1;
        chk("reset_mode", mode, 0);
        chk("reset_blink", blink, 1);
        chk("reset_pulses", {sec_adv, min_adv, hour_adv, sec_clr}, 0);

        // 1: tick cadence after reset release
        reset = 1'b1;
        rel = cyc;
        s0 = sec_times.size();
        step(13);
        chk("t1_sec_count", sec_times.size() - s0, 3);
        if (sec_times.size() - s0 >= 3) begin
            chk("t1_sec_at_4", sec_times[s0] - rel, 4);
            chk("t1_sec_at_8", sec_times[s0 + 1] - rel, 8);
            chk("t1_sec_at_12", sec_times[s0 + 2] - rel, 12);
        end
        chk("t1_no_min_hour", min_cnt + hour_cnt, 0);

        // 2: carries on tick
        sec_at_max = 1'b1; min_at_max = 1'b1;
        wait_sec("t2_tick_seen_a");
        chk("t2_carry_both", {min_adv, hour_adv}, 2'b11);
        sec_at_max = 1'b1; min_at_max = 1'b0;
        wait_sec("t2_tick_seen_b");
        chk("t2_carry_min_only", {min_adv, hour_adv}, 2'b10);
        sec_at_max = 1'b0;

        // 3: SET_HOUR, ticks suppressed, inc gives hour_adv
        press_mode();
        s0 = sec_cnt; h0 = hour_cnt; m0 = min_cnt;
        step(20);
        chk("t3_mode_set_hour", mode, 1);
        chk("t3_no_sec_adv", sec_cnt - s0, 0);
        repeat (3) press_inc();
        chk("t3_hour_pulses", hour_cnt - h0, 3);
        chk("t3_min_pulses", min_cnt - m0, 0);

        // 4: SET_MIN no hour carry, return to RUN clears seconds
        press_mode();
        chk("t4_mode_set_min", mode, 2);
        min_at_max = 1'b1;
        m0 = min_cnt; h0 = hour_cnt;
        press_inc();
        chk("t4_min_pulse", min_cnt - m0, 1);
        chk("t4_no_hour_carry", hour_cnt - h0, 0);
        min_at_max = 1'b0;
        c0 = clr_cnt;
        press_mode();
        step(4);
        chk("t4_mode_run", mode, 0);
        chk("t4_clr_once", clr_cnt - c0, 1);
        chk("t4_first_sec_after_clr", last_sec - last_clr, TD);

        // 5: simultaneous mode/inc rise, then held inc
        press_mode();
        h0 = hour_cnt; m0 = min_cnt;
        mode_btn = 1'b1; inc_btn = 1'b1;
        step(1);
        mode_btn = 1'b0; inc_btn = 1'b0;
        step(2);
        chk("t5_mode_set_min", mode, 2);
        chk("t5_no_hour_adv", hour_cnt - h0, 0);
        inc_btn = 1'b1;
        step(10);
        chk("t5_single_min_adv", min_cnt - m0, 1);

        // 6: reset with inc held in SET_MIN
        reset = 1'b0;
        step(1);
        chk("t6_mode_run", mode, 0);
        chk("t6_pulses_zero", {sec_adv, min_adv, hour_adv, sec_clr}, 0);
        chk("t6_blink_on", blink, 1);
        reset = 1'b1;
        m0 = min_cnt; h0 = hour_cnt;
        step(10);
        chk("t6_no_min_adv", min_cnt - m0, 0);
        chk("t6_no_hour_adv", hour_cnt - h0, 0);
        inc_btn = 1'b0;
        step(2);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
